// File: rtl/rf_sequencer.sv
// rf_sequencer: multi-cycle fetch/decode/execute controller for the
// register-file/ALU datapath (ADDI, ADD, SUB, AND, OR, BEQ, BNE).
module rf_sequencer #(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_valid,
    input  logic [31:0]         imem_data,
    output logic [4:0]          ad1,
    output logic [4:0]          ad2,
    output logic [4:0]          ad3,
    output logic                we3,
    output logic [31:0]         imm_op,
    output logic                alusrc,
    output logic [2:0]          aluctrl,
    input  logic                eq,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         ir_q;
    logic [4:0]          ad1_q, ad2_q, ad3_q;
    logic [31:0]         imm_q;
    logic                src_q;
    logic [2:0]          ctl_q;
    logic                br_q, bne_q;

    logic                dec_ok, dec_br, dec_src;
    logic [2:0]          dec_ctl;
    logic [31:0]         dec_imm;
    logic                taken;

    logic [6:0] op, f7;
    logic [2:0] f3;

    assign op = ir_q[6:0];
    assign f3 = ir_q[14:12];
    assign f7 = ir_q[31:25];

    always_comb begin
        dec_ok  = 1'b0;
        dec_br  = 1'b0;
        dec_src = 1'b0;
        dec_ctl = 3'b000;
        dec_imm = '0;
        case (op)
            7'b0010011: begin
                if (f3 == 3'b000) begin
                    dec_ok  = 1'b1;
                    dec_src = 1'b1;
                    dec_imm = {{20{ir_q[31]}}, ir_q[31:20]};
                end
            end
            7'b0110011: begin
                if (f7 == 7'b0000000 && f3 == 3'b000) begin
                    dec_ok = 1'b1;
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dec_ok  = 1'b1;
                    dec_ctl = 3'b001;
                end else if (f7 == 7'b0000000 && f3 == 3'b111) begin
                    dec_ok  = 1'b1;
                    dec_ctl = 3'b010;
                end else if (f7 == 7'b0000000 && f3 == 3'b110) begin
                    dec_ok  = 1'b1;
                    dec_ctl = 3'b011;
                end
            end
            7'b1100011: begin
                if (f3 == 3'b000 || f3 == 3'b001) begin
                    dec_ok  = 1'b1;
                    dec_br  = 1'b1;
                    dec_ctl = 3'b001;
                    dec_imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                               ir_q[30:25], ir_q[11:8], 1'b0};
                end
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // eq only feeds the pc register, never an output directly
    assign taken = bne_q ? ~eq : eq;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (imem_valid) state_d = S_DECODE;
            S_DECODE: state_d = dec_ok ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (br_q) begin
                    state_d = S_FETCH;
                    pc_d    = taken ? pc_q + PC_WIDTH'($signed(imm_q))
                                    : pc_q + PC_WIDTH'(4);
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                pc_d    = pc_q + PC_WIDTH'(4);
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ad1_q   <= '0;
            ad2_q   <= '0;
            ad3_q   <= '0;
            imm_q   <= '0;
            src_q   <= 1'b0;
            ctl_q   <= 3'b000;
            br_q    <= 1'b0;
            bne_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == S_FETCH && imem_valid) begin
                ir_q <= imem_data;
            end
            if (state_q == S_DECODE && dec_ok) begin
                ad1_q <= ir_q[19:15];
                ad2_q <= ir_q[24:20];
                ad3_q <= ir_q[11:7];
                imm_q <= dec_imm;
                src_q <= dec_src;
                ctl_q <= dec_ctl;
                br_q  <= dec_br;
                bne_q <= ir_q[12];
            end
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign we3       = (state_q == S_WB) && (ad3_q != 5'd0);
    assign halted    = (state_q == S_HALT);
    assign ad1       = ad1_q;
    assign ad2       = ad2_q;
    assign ad3       = ad3_q;
    assign imm_op    = imm_q;
    assign alusrc    = src_q;
    assign aluctrl   = ctl_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Scoreboard bench for rf_sequencer: a memory driver predicts each
// instruction's effect, a monitor checks what the sequencer presents.
module tb_rf_sequencer;

    localparam int K_ADDI = 0;
    localparam int K_ADD  = 1;
    localparam int K_SUB  = 2;
    localparam int K_AND  = 3;
    localparam int K_OR   = 4;
    localparam int K_BEQ  = 5;
    localparam int K_BNE  = 6;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [4:0]  a1, a2, a3;
        logic [31:0] imm;
        logic        chk_imm;
        logic        src;
        logic [2:0]  ctl;
        int          we;
        logic        br;
        logic        halt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic [4:0]  ad1, ad2, ad3;
    logic        we3;
    logic [31:0] imm_op;
    logic        alusrc;
    logic [2:0]  aluctrl;
    logic        eq;
    logic [31:0] pc;
    logic        halted;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [31:0] model_pc = 32'h0;

    rf_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .ad1(ad1), .ad2(ad2), .ad3(ad3), .we3(we3),
        .imm_op(imm_op), .alusrc(alusrc), .aluctrl(aluctrl),
        .eq(eq), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_we3", 32'(we3), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ad1", 32'(ad1), 0);
        chk("rst_ad2", 32'(ad2), 0);
        chk("rst_ad3", 32'(ad3), 0);
        chk("rst_imm", imm_op, 0);
        chk("rst_alusrc", 32'(alusrc), 0);
        chk("rst_aluctrl", 32'(aluctrl), 0);
    endtask

    // Encode an instruction and derive its expected effect from the ISA rules
    task automatic predict(input int k, input logic [4:0] rs1, rs2, rd,
                           input int imm, input logic eqv,
                           output logic [31:0] ins, output exp_t e);
        logic [11:0] i12;
        logic [12:0] b;
        logic [31:0] sx;
        logic        tk;
        i12 = 12'(imm);
        b   = 13'(imm);
        sx  = 32'(imm);
        e.pc = model_pc;
        e.npc = model_pc + 32'd4;
        e.imm = sx;
        e.chk_imm = 1'b1;
        e.src = 1'b0;
        e.ctl = 3'b000;
        e.we = 0;
        e.br = 1'b0;
        e.halt = 1'b0;
        ins = 32'h0;
        case (k)
            K_ADDI: begin
                ins = {i12, rs1, 3'b000, rd, 7'b0010011};
                e.src = 1'b1;
            end
            K_ADD: ins = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_SUB: begin
                ins = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
                e.ctl = 3'b001;
            end
            K_AND: begin
                ins = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
                e.ctl = 3'b010;
            end
            K_OR: begin
                ins = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
                e.ctl = 3'b011;
            end
            default: begin
                ins = {b[12], b[10:5], rs2, rs1,
                       (k == K_BNE) ? 3'b001 : 3'b000,
                       b[4:1], b[11], 7'b1100011};
                e.ctl = 3'b001;
                e.br = 1'b1;
                tk = (k == K_BEQ) ? eqv : !eqv;
                if (tk) e.npc = model_pc + sx;
            end
        endcase
        if (k >= K_ADD && k <= K_OR) e.chk_imm = 1'b0;
        if (!e.br) e.we = (ins[11:7] != 5'd0) ? 1 : 0;
        e.a1 = ins[19:15];
        e.a2 = ins[24:20];
        e.a3 = ins[11:7];
    endtask

    // Memory side: spurious valids outside FETCH, d wait cycles, then data
    task automatic serve(input logic [31:0] ins, input exp_t e,
                         input int d, input logic eqv);
        int t = 0;
        while (!imem_req && t < 100) begin
            imem_valid = 1'($urandom_range(0, 1));
            imem_data  = $urandom;
            @(negedge clk);
            t++;
        end
        if (!imem_req) begin
            errors++;
            $display("FAIL fetch_timeout: imem_req=0 expected 1 at %0t", $time);
            return;
        end
        imem_valid = 1'b0;
        repeat (d) @(negedge clk);
        imem_valid = 1'b1;
        imem_data  = ins;
        eq         = eqv;
        @(posedge clk);
        sb.push_back(e);
        model_pc = e.npc;
        @(negedge clk);
        imem_valid = 1'b0;
    endtask

    task automatic run(input int k, input logic [4:0] rs1, rs2, rd,
                       input int imm, input int d, input logic eqv);
        logic [31:0] ins;
        exp_t e;
        predict(k, rs1, rs2, rd, imm, eqv, ins, e);
        serve(ins, e, d, eqv);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        chk("idle_req", 32'(imem_req), 0);
        @(negedge clk);
        chk("first_req", 32'(imem_req), 1);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_we3", 32'(we3), 0);
    endtask

    // Monitor: one window per instruction, opened when the fetch completes
    initial begin
        exp_t cur;
        bit   have = 0;
        bit   prev_req = 0;
        int   cnt = 0;
        int   wes = 0;
        logic [31:0] faddr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have = 0;
                prev_req = 0;
                continue;
            end
            if (imem_req && !prev_req) begin
                if (have) chk("we3_pulses", 32'(wes), 32'(cur.we));
                have  = 0;
                faddr = imem_addr;
            end
            if (imem_req) begin
                chk("addr_stable", imem_addr, faddr);
                chk("pc_eq_addr", pc, imem_addr);
            end
            if (!imem_req && prev_req) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: fetch done with no prediction");
                end else begin
                    cur  = sb.pop_front();
                    have = 1;
                    cnt  = 0;
                    wes  = 0;
                    chk("fetch_pc", faddr, cur.pc);
                end
            end
            if (have && we3) wes++;
            if (have && !imem_req) begin
                cnt++;
                if (cnt == 2 && !cur.halt) begin
                    chk("ex_ad1", 32'(ad1), 32'(cur.a1));
                    chk("ex_ad2", 32'(ad2), 32'(cur.a2));
                    chk("ex_ad3", 32'(ad3), 32'(cur.a3));
                    chk("ex_alusrc", 32'(alusrc), 32'(cur.src));
                    chk("ex_aluctrl", 32'(aluctrl), 32'(cur.ctl));
                    chk("ex_halted", 32'(halted), 0);
                    if (cur.chk_imm) chk("ex_imm", imm_op, cur.imm);
                end
                if (cnt == 3 && !cur.halt) begin
                    chk("wb_ad3", 32'(ad3), 32'(cur.a3));
                    chk("wb_aluctrl", 32'(aluctrl), 32'(cur.ctl));
                    chk("wb_alusrc", 32'(alusrc), 32'(cur.src));
                end
            end
            if (have && halted) begin
                chk("halt_expected", 32'(cur.halt), 1);
                chk("halt_we3", 32'(wes), 0);
                have = 0;
            end
            prev_req = imem_req;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t        he;
        int          t;
        rst_n      = 1'b0;
        imem_valid = 1'b0;
        imem_data  = 32'h0;
        eq         = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        release_reset();

        run(K_ADDI, 5'd0, 5'd0, 5'd10, 5, 0, 1'b0);
        run(K_ADDI, 5'd0, 5'd0, 5'd0, 1, 3, 1'b0);
        run(K_BNE, 5'd10, 5'd0, 5'd0, -4, 0, 1'b0);
        run(K_ADD, 5'd1, 5'd2, 5'd3, 0, 1, 1'b0);
        run(K_BNE, 5'd10, 5'd0, 5'd0, -4, 0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            int k, imm;
            k = $urandom_range(0, 6);
            imm = (k >= K_BEQ) ? 2 * ($urandom_range(0, 4095) - 2048)
                               : $urandom_range(0, 4095) - 2048;
            run(k, 5'($urandom), 5'($urandom), 5'($urandom), imm,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        run(K_ADDI, 5'd0, 5'd0, 5'd5, 7, 0, 1'b0);
        t = 0;
        while (!we3 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("wb_reached", 32'(we3), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_we3", 32'(we3), 0);
        chk("async_pc", pc, 32'h0);
        chk_reset_vals();
        sb.delete();
        model_pc = 32'h0;
        release_reset();

        run(K_OR, 5'd4, 5'd6, 5'd7, 0, 2, 1'b0);
        run(K_BEQ, 5'd1, 5'd1, 5'd0, 16, 0, 1'b1);

        he = '{pc: model_pc, npc: model_pc, a1: 0, a2: 0, a3: 0, imm: 0,
               chk_imm: 0, src: 0, ctl: 0, we: 0, br: 0, halt: 1};
        serve(32'hFFFF_FFFF, he, 1, 1'b0);
        repeat (6) begin
            imem_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt_flag", 32'(halted), 1);
            chk("halt_req", 32'(imem_req), 0);
            chk("halt_we3", 32'(we3), 0);
            chk("halt_pc", pc, he.pc);
        end
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
